// File: rtl/cmd_sched.sv
// Command scheduler: buffers UART command words in a FIFO and hands them one at a time
// to a command processor. Optional completion timeout is enabled by CMD_SCHED_TIMEOUT_EN.
module cmd_sched #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [25:0] TMO_CYCLES = 26'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] uart_cmd,
  input  logic        uart_cmd_rdy,
  output logic        uart_clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic        abort,
  output logic        resp_vld,
  output logic [7:0]  resp,
  output logic [4:0]  q_cnt,
  output logic        ovfl,
  output logic        busy
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
  localparam logic [7:0]  RESP_OK  = 8'hA5;
  localparam logic [7:0]  RESP_TMO = 8'hE0;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYCLES == '0) begin : g_bad_param
    $error("cmd_sched: DEPTH must be a power of 2 in 2..16 and TMO_CYCLES nonzero");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_cnt;
  logic          r_ovfl;
  logic          r_cmd_rdy;
  logic          r_resp_vld;
  logic [7:0]    r_resp;
  logic          r_busy;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_tmo_hit;

  assign w_full = (r_cnt == DEPTH_C);
  // abort outranks every other source of state change, including the same-cycle push
  assign w_push = uart_cmd_rdy && !w_full && !abort;
  assign w_pop  = (r_state == ISSUE) && clr_cmd_rdy && !abort;

  assign uart_clr_cmd_rdy = uart_cmd_rdy;
  assign cmd              = r_mem[r_rptr];
  assign cmd_rdy          = r_cmd_rdy;
  assign resp_vld         = r_resp_vld;
  assign resp             = r_resp;
  assign q_cnt            = r_cnt;
  assign ovfl             = r_ovfl;
  assign busy             = r_busy;

`ifdef CMD_SCHED_TIMEOUT_EN
  logic [25:0] r_tmo;
  assign w_tmo_hit = (r_tmo == TMO_CYCLES - 26'd1);
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= uart_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovfl <= 1'b0;
    end else if (abort) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovfl <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 5'd1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 5'd1;
      if (uart_cmd_rdy && w_full) r_ovfl <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cmd_rdy  <= 1'b0;
      r_resp_vld <= 1'b0;
      r_resp     <= '0;
      r_busy     <= 1'b0;
`ifdef CMD_SCHED_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else if (abort) begin
      r_state    <= IDLE;
      r_cmd_rdy  <= 1'b0;
      r_resp_vld <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_resp_vld <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_cnt != '0) begin
            r_state   <= ISSUE;
            r_cmd_rdy <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ISSUE: begin
          if (clr_cmd_rdy) begin
            r_state   <= BUSY;
            r_cmd_rdy <= 1'b0;
`ifdef CMD_SCHED_TIMEOUT_EN
            r_tmo     <= '0;
`endif
          end
        end
        BUSY: begin
          // a completion arriving on the terminal count still reports success
          if (send_resp) begin
            r_state    <= RESP;
            r_resp     <= RESP_OK;
            r_resp_vld <= 1'b1;
          end else if (w_tmo_hit) begin
            r_state    <= RESP;
            r_resp     <= RESP_TMO;
            r_resp_vld <= 1'b1;
          end
`ifdef CMD_SCHED_TIMEOUT_EN
          else begin
            r_tmo <= r_tmo + 26'd1;
          end
`endif
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Directed scoreboard bench for cmd_sched (DEPTH=4, TMO_CYCLES=16).
module tb_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] uart_cmd;
  logic        uart_cmd_rdy;
  logic        uart_clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        abort;
  logic        resp_vld;
  logic [7:0]  resp;
  logic [4:0]  q_cnt;
  logic        ovfl;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] q_exp[$];

  cmd_sched #(.DEPTH(4), .TMO_CYCLES(26'd16)) dut (
    .clk(clk), .rst(rst),
    .uart_cmd(uart_cmd), .uart_cmd_rdy(uart_cmd_rdy), .uart_clr_cmd_rdy(uart_clr_cmd_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .abort(abort),
    .resp_vld(resp_vld), .resp(resp), .q_cnt(q_cnt), .ovfl(ovfl), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    uart_cmd     = w;
    uart_cmd_rdy = 1'b1;
    #1;
    chk("uart_ack", 32'(uart_clr_cmd_rdy), 32'd1);
    if (q_exp.size() < 4) q_exp.push_back(w);
    @(posedge clk);
    #1;
    uart_cmd_rdy = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    for (int n = 0; n < 20 && cmd_rdy !== 1'b1; n++) tick();
    chk(tag, 32'(cmd_rdy), 32'd1);
  endtask

  task automatic issue();
    logic [15:0] e;
    wait_rdy("cmd_rdy_wait");
    e = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hxxxx;
    chk("cmd_head", 32'(cmd), 32'(e));
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_drop", 32'(cmd_rdy), 32'd0);
  endtask

  task automatic respond(input int gap);
    repeat (gap) tick();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("resp_vld", 32'(resp_vld), 32'd1);
    chk("resp_ok", 32'(resp), 32'h0A5);
    tick();
    chk("resp_vld_pulse", 32'(resp_vld), 32'd0);
  endtask

  initial begin
    logic [15:0] e;
    logic        seen;
    rst = 1'b1; uart_cmd = '0; uart_cmd_rdy = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_resp_vld", 32'(resp_vld), 32'd0);
    chk("rst_resp", 32'(resp), 32'h00);
    chk("rst_q_cnt", 32'(q_cnt), 32'd0);
    chk("rst_ovfl", 32'(ovfl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // single command, latency, response
    push(16'h2400);
    chk("lat_early", 32'(cmd_rdy), 32'd0);
    chk("single_q_cnt", 32'(q_cnt), 32'd1);
    tick(); tick();
    chk("lat_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("lat_busy", 32'(busy), 32'd1);
    issue();
    chk("single_q_empty", 32'(q_cnt), 32'd0);
    respond(9);
    chk("single_idle", 32'(busy), 32'd0);

    // overflow while busy, clr_cmd_rdy ignored in BUSY, in-order drain
    push(16'h1000);
    issue();
    for (int i = 1; i <= 5; i++) push(16'h1000 + 16'(i));
    chk("ovf_q_cnt", 32'(q_cnt), 32'd4);
    chk("ovf_flag", 32'(ovfl), 32'd1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("busy_no_pop", 32'(q_cnt), 32'd4);
    respond(2);
    for (int i = 0; i < 4; i++) begin
      issue();
      respond(1);
    end
    chk("ovf_drained", 32'(q_cnt), 32'd0);
    chk("ovf_sticky", 32'(ovfl), 32'd1);

    // simultaneous push and pop with q_cnt=2, write pointer wraps
    push(16'h2000);
    push(16'h2001);
    wait_rdy("sim_rdy");
    chk("sim_q_cnt_pre", 32'(q_cnt), 32'd2);
    uart_cmd = 16'h2002; uart_cmd_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    chk("sim_ack", 32'(uart_clr_cmd_rdy), 32'd1);
    e = q_exp.pop_front();
    chk("sim_head", 32'(cmd), 32'(e));
    q_exp.push_back(16'h2002);
    tick();
    uart_cmd_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    chk("sim_q_cnt", 32'(q_cnt), 32'd2);
    respond(1);
    issue(); respond(1);
    issue(); respond(1);
    chk("sim_drained", 32'(q_cnt), 32'd0);

    // abort while BUSY with q_cnt=3; same-cycle push and send_resp discarded
    push(16'h3000);
    issue();
    for (int i = 1; i <= 3; i++) push(16'h3000 + 16'(i));
    chk("abort_pre_q", 32'(q_cnt), 32'd3);
    chk("abort_pre_ovfl", 32'(ovfl), 32'd1);
    abort = 1'b1; uart_cmd = 16'h3004; uart_cmd_rdy = 1'b1; send_resp = 1'b1;
    tick();
    abort = 1'b0; uart_cmd_rdy = 1'b0; send_resp = 1'b0;
    q_exp.delete();
    chk("abort_q_cnt", 32'(q_cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ovfl", 32'(ovfl), 32'd0);
    chk("abort_resp_vld", 32'(resp_vld), 32'd0);
    chk("abort_cmd_rdy", 32'(cmd_rdy), 32'd0);
    repeat (3) tick();
    chk("abort_stay_idle", 32'(busy), 32'd0);

    // completion timeout
    push(16'h4000);
    issue();
`ifdef CMD_SCHED_TIMEOUT_EN
    repeat (15) tick();
    chk("tmo_early", 32'(resp_vld), 32'd0);
    tick();
    chk("tmo_vld", 32'(resp_vld), 32'd1);
    chk("tmo_resp", 32'(resp), 32'h0E0);
    tick();
    chk("tmo_idle", 32'(busy), 32'd0);
`else
    seen = 1'b0;
    repeat (1000) begin
      tick();
      if (resp_vld === 1'b1) seen = 1'b1;
    end
    chk("no_tmo_resp", 32'(seen), 32'd0);
    chk("no_tmo_busy", 32'(busy), 32'd1);
    respond(0);
`endif

    // asynchronous reset mid-ISSUE, in-flight command lost
    push(16'h5000);
    push(16'h5001);
    wait_rdy("rst_mid_rdy");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("arst_q_cnt", 32'(q_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    q_exp.delete();
    #1;
    rst = 1'b0;
    tick();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("idle_send_resp", 32'(resp_vld), 32'd0);
    chk("idle_stays", 32'(busy), 32'd0);
    push(16'h6000);
    issue();
    respond(3);
    chk("final_q_cnt", 32'(q_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
